// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: front/back PC pair, imem req/ack handshake,
// single-entry fetch buffer feeding the IF/ID register, delayed-branch
// redirect and squash handling.
module instr_fetch_unit #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 32,
   parameter int PC_STEP = 4
) (
   input  logic               Clk,
   input  logic               Rst,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_ack,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   input  logic               squash,
   output logic [ADDR_W-1:0]  fetch_pc,
   output logic [INSTR_W-1:0] fetch_instr,
   output logic               fetch_valid,
   output logic               ifid_le,
   output logic               ifid_clr,
   output logic [ADDR_W-1:0]  pc_front,
   output logic [ADDR_W-1:0]  pc_back
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

   state_t state, state_nxt;
   logic   ack_ok;

   // an ack only counts while a request is outstanding
   assign ack_ok = (state == FETCH) && imem_ack;

   // state register
   always_ff @(posedge Clk) begin
      if (Rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state logic; squash overrides stall in HOLD
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = FETCH;
         FETCH:   if (imem_ack) state_nxt = HOLD;
         HOLD:    if (squash || !stall) state_nxt = FETCH;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      imem_req = (state == FETCH);
   end

   // address tracks pc_front, which only moves on the ack edge
   assign imem_addr = pc_front;
   assign ifid_le   = fetch_valid & ~stall;

   // PC pair: ack shifts back->front; a branch target replaces the back PC
   // and wins over the sequential increment
   always_ff @(posedge Clk) begin
      if (Rst) begin
         pc_front <= '0;
         pc_back  <= ADDR_W'(PC_STEP);
      end else begin
         if (ack_ok) pc_front <= pc_back;
         if (branch_taken) pc_back <= branch_target;
         else if (ack_ok)  pc_back <= pc_back + ADDR_W'(PC_STEP);
      end
   end

   // fetch buffer; a squashed return is dropped but the PC still advances
   always_ff @(posedge Clk) begin
      if (Rst) begin
         fetch_pc    <= '0;
         fetch_instr <= '0;
         fetch_valid <= 1'b0;
         ifid_clr    <= 1'b0;
      end else begin
         if (ack_ok && !squash) begin
            fetch_pc    <= pc_front;
            fetch_instr <= imem_rdata;
         end
         if (squash)                      fetch_valid <= 1'b0;
         else if (ack_ok)                 fetch_valid <= 1'b1;
         else if (state == HOLD && !stall) fetch_valid <= 1'b0;
         ifid_clr <= squash;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
   localparam int AW = 8;
   localparam int IW = 32;
   localparam int STEP = 4;

   logic          Clk = 1'b0;
   logic          Rst;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_rdata;
   logic          imem_ack;
   logic          stall;
   logic          branch_taken;
   logic [AW-1:0] branch_target;
   logic          squash;
   logic [AW-1:0] fetch_pc;
   logic [IW-1:0] fetch_instr;
   logic          fetch_valid;
   logic          ifid_le;
   logic          ifid_clr;
   logic [AW-1:0] pc_front;
   logic [AW-1:0] pc_back;

   always #5 Clk = ~Clk;

   instr_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .PC_STEP(STEP)) dut (
      .Clk(Clk), .Rst(Rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
      .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target), .squash(squash),
      .fetch_pc(fetch_pc), .fetch_instr(fetch_instr), .fetch_valid(fetch_valid),
      .ifid_le(ifid_le), .ifid_clr(ifid_clr), .pc_front(pc_front), .pc_back(pc_back)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: 0 = not yet requesting, 1 = waiting on memory, 2 = holding a word
   int            m_st;
   logic [AW-1:0] m_front, m_back, m_fpc;
   logic [IW-1:0] m_finstr;
   logic          m_valid, m_clr;
   int            mem_lat, wait_cnt;
   bit            rnd_lat;
   logic [AW-1:0] q_addr[$];

   task automatic m_reset();
      m_st = 0; m_front = '0; m_back = 8'(STEP); m_fpc = '0; m_finstr = '0;
      m_valid = 1'b0; m_clr = 1'b0; wait_cnt = 0;
   endtask

   task automatic chk_regs();
      chk("fetch_pc", fetch_pc, m_fpc);
      chk("fetch_instr", fetch_instr, m_finstr);
      chk("fetch_valid", fetch_valid, m_valid);
      chk("ifid_clr", ifid_clr, m_clr);
      chk("pc_front", pc_front, m_front);
      chk("pc_back", pc_back, m_back);
      chk("imem_req_q", imem_req, m_st == 1);
   endtask

   // one clock: drive at negedge, check combinational outputs, advance model, check state
   task automatic cycle(input logic st, input logic br, input logic [AW-1:0] tgt, input logic sq);
      logic          a;
      logic          ack_eff;
      logic [IW-1:0] rd;
      a  = 1'b0;
      rd = $urandom;
      if (m_st == 1) begin
         if (wait_cnt >= mem_lat) a = 1'b1;
         else wait_cnt++;
      end else if ($urandom_range(0, 7) == 0) begin
         a = 1'b1;  // stray ack, must be ignored
      end
      stall = st; branch_taken = br; branch_target = tgt; squash = sq;
      imem_ack = a; imem_rdata = rd;
      #1;
      chk("imem_req", imem_req, m_st == 1);
      if (m_st == 1) begin
         chk("imem_addr", imem_addr, m_front);
         if (a) q_addr.push_back(imem_addr);
      end
      chk("ifid_le", ifid_le, m_valid & ~st);
      ack_eff = (m_st == 1) && a;
      if (ack_eff) begin
         if (!sq) begin m_fpc = m_front; m_finstr = rd; end
         m_valid = !sq;
         m_front = m_back;
         m_back  = br ? tgt : m_back + 8'(STEP);
         m_st = 2; wait_cnt = 0;
         if (rnd_lat) mem_lat = $urandom_range(0, 3);
      end else begin
         if (br) m_back = tgt;
         if (sq || (m_st == 2 && !st)) m_valid = 1'b0;
         if (m_st == 0) m_st = 1;
         else if (m_st == 2 && (sq || !st)) m_st = 1;
      end
      m_clr = sq;
      @(negedge Clk);
      chk_regs();
   endtask

   task automatic do_reset(input logic ack_during);
      Rst = 1'b1; imem_ack = ack_during; stall = 1'b0; branch_taken = 1'b0; squash = 1'b0;
      @(negedge Clk);
      m_reset();
      chk_regs();
      chk("imem_addr_rst", imem_addr, 8'h00);
      Rst = 1'b0; imem_ack = 1'b0;
   endtask

   initial begin
      Rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
      branch_taken = 1'b0; branch_target = '0; squash = 1'b0;
      mem_lat = 0; rnd_lat = 1'b0;
      @(negedge Clk);
      do_reset(1'b0);
      chk("rst_pc_back", pc_back, 8'h04);

      // zero-wait sequential fetch, then delayed branch to 0x40 issued in HOLD
      cycle(0, 0, 0, 0);          // IDLE
      cycle(0, 0, 0, 0);          // fetch 0x00
      cycle(0, 0, 0, 0);          // HOLD
      cycle(0, 0, 0, 0);          // fetch 0x04
      chk("front_08", pc_front, 8'h08);
      chk("back_0c", pc_back, 8'h0C);
      cycle(0, 1, 8'h40, 0);      // HOLD + branch
      cycle(0, 0, 0, 0);          // delay slot 0x08
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);          // fetch 0x40
      chk("seq0", q_addr[0], 8'h00);
      chk("seq1", q_addr[1], 8'h04);
      chk("seq2", q_addr[2], 8'h08);
      chk("seq3", q_addr[3], 8'h40);

      // PC wrap: back PC at 0xFC advances to 0x00
      cycle(0, 1, 8'hFC, 0);      // HOLD + branch
      cycle(0, 0, 0, 0);          // fetch 0x44
      chk("wrap_front", pc_front, 8'hFC);
      chk("wrap_back", pc_back, 8'h00);

      // squash coincident with ack at 0xFC
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 1);
      chk("sq_valid", fetch_valid, 1'b0);
      chk("sq_clr", ifid_clr, 1'b1);
      cycle(0, 0, 0, 0);
      chk("sq_clr_end", ifid_clr, 1'b0);

      // five stalled cycles in HOLD
      cycle(0, 0, 0, 0);          // fetch 0x00
      for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
      chk("stall_valid", fetch_valid, 1'b1);

      // three-cycle memory latency
      mem_lat = 3;
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);

      // reset while a request is outstanding
      do_reset(1'b0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);          // in FETCH, memory still waiting
      do_reset(1'b1);
      chk("rst_mid_req", imem_req, 1'b0);

      // randomized traffic
      rnd_lat = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         logic [AW-1:0] t;
         t = 8'($urandom) & 8'hFC;
         cycle($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, t, $urandom_range(0, 11) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
